// File: rtl/ras_pkg.sv
// Shared types and widths for the return-address-stack controller.
// The default stack geometry lives here so the tracking record width follows it.
package ras_pkg;

    localparam int RAS_DEPTH = 8;
    localparam int RAS_AW    = 32;
    localparam int PTR_W     = $clog2(RAS_DEPTH);
    localparam int CNT_W     = $clog2(RAS_DEPTH + 1);

    typedef enum logic [1:0] {
        NONE    = 2'd0,
        PUSH    = 2'd1,
        POP     = 2'd2,
        REPLACE = 2'd3
    } ras_op_e;

    // Undo information for one speculative stack operation.
    typedef struct packed {
        logic              valid;
        logic [PTR_W-1:0]  tos_before;
        logic [CNT_W-1:0]  count_before;
        logic [PTR_W-1:0]  slot;
        logic [RAS_AW-1:0] old_data;
    } ras_rec_t;

    localparam ras_rec_t REC_EMPTY = '{
        valid:        1'b0,
        tos_before:   {PTR_W{1'b0}},
        count_before: {CNT_W{1'b0}},
        slot:         {PTR_W{1'b0}},
        old_data:     {RAS_AW{1'b0}}
    };

    function automatic logic [CNT_W-1:0] cnt_inc_sat(
        input logic [CNT_W-1:0] cnt,
        input logic [CNT_W-1:0] max_cnt
    );
        logic [CNT_W-1:0] res;
        if (cnt == max_cnt) begin
            res = cnt;
        end else begin
            res = cnt + CNT_W'(1);
        end
        return res;
    endfunction

endpackage

// File: rtl/ras_track_reg.sv
// One pipeline-stage slot of the stack-operation tracking pipeline.
// Clear wins over load; with neither asserted the record holds.
module ras_track_reg
    import ras_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     i_load,
    input  logic     i_clr,
    input  ras_rec_t i_rec,
    output ras_rec_t o_rec
);

    ras_rec_t r_rec;

    // Record register with synchronous reset, clear and stallable load.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rec <= REC_EMPTY;
        end else if (i_clr) begin
            r_rec <= REC_EMPTY;
        end else if (i_load) begin
            r_rec <= i_rec;
        end else begin
            r_rec <= r_rec;
        end
    end

    assign o_rec = r_rec;

endmodule

// File: rtl/ras_ctrl.sv
// Return-address-stack controller: speculative push/pop/replace from IF with
// ID/EX undo records so squashed calls and returns restore the exact stack state.
module ras_ctrl
    import ras_pkg::*;
#(
    parameter int DEPTH = RAS_DEPTH,
    parameter int AW    = RAS_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [AW-1:0] push_addr,
    input  logic          pop,
    input  logic          PL_stall,
    input  logic          PL_flush,
    input  logic          rollback_id,
    input  logic          rollback_ex,
    output logic [AW-1:0] top_addr,
    output logic          top_valid,
    output logic          ras_full
);

    logic [AW-1:0]    r_mem [DEPTH];
    logic [PTR_W-1:0] r_tos;
    logic [CNT_W-1:0] r_count;

    ras_rec_t         w_id_rec;
    ras_rec_t         w_ex_rec;
    ras_rec_t         w_new_rec;
    ras_op_e          w_op;
    logic             w_empty;
    logic             w_rb_any;
    logic             w_accept;
    logic [PTR_W-1:0] w_new_slot;

    logic [PTR_W-1:0] w_tos_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    logic             w_we_a;
    logic [PTR_W-1:0] w_wa_a;
    logic [AW-1:0]    w_wd_a;
    logic             w_we_b;
    logic [PTR_W-1:0] w_wa_b;
    logic [AW-1:0]    w_wd_b;

    logic             w_id_load;
    logic             w_id_clr;
    logic             w_ex_load;
    logic             w_ex_clr;

    assign w_empty    = (r_count == {CNT_W{1'b0}});
    assign w_rb_any   = rollback_id | rollback_ex;
    assign w_accept   = ~PL_stall & ~PL_flush & ~w_rb_any;
    assign w_new_slot = (w_op == PUSH) ? (r_tos + PTR_W'(1)) : r_tos;

    // Decode the IF request; a replace or pop on an empty stack degrades.
    always_comb begin
        w_op = NONE;
        if (push && pop) begin
            w_op = w_empty ? PUSH : REPLACE;
        end else if (push) begin
            w_op = PUSH;
        end else if (pop) begin
            w_op = w_empty ? NONE : POP;
        end else begin
            w_op = NONE;
        end
    end

    // Undo record for the op accepted this cycle.
    always_comb begin
        w_new_rec              = REC_EMPTY;
        w_new_rec.valid        = w_accept & (w_op != NONE);
        w_new_rec.tos_before   = r_tos;
        w_new_rec.count_before = r_count;
        w_new_rec.slot         = w_new_slot;
        w_new_rec.old_data     = r_mem[w_new_slot];
    end

    // Next stack state; port B is written last so the EX restore beats the ID one.
    always_comb begin
        w_tos_nxt   = r_tos;
        w_count_nxt = r_count;
        w_we_a      = 1'b0;
        w_wa_a      = w_id_rec.slot;
        w_wd_a      = w_id_rec.old_data;
        w_we_b      = 1'b0;
        w_wa_b      = w_new_slot;
        w_wd_b      = push_addr;
        if (w_rb_any) begin
            if (rollback_id && w_id_rec.valid) begin
                w_we_a      = 1'b1;
                w_tos_nxt   = w_id_rec.tos_before;
                w_count_nxt = w_id_rec.count_before;
            end else begin
                w_we_a      = 1'b0;
            end
            if (rollback_ex && w_ex_rec.valid) begin
                w_we_b      = 1'b1;
                w_wa_b      = w_ex_rec.slot;
                w_wd_b      = w_ex_rec.old_data;
                w_tos_nxt   = w_ex_rec.tos_before;
                w_count_nxt = w_ex_rec.count_before;
            end else begin
                w_we_b      = 1'b0;
            end
        end else if (w_accept) begin
            case (w_op)
                PUSH: begin
                    w_we_b      = 1'b1;
                    w_tos_nxt   = w_new_slot;
                    w_count_nxt = cnt_inc_sat(r_count, CNT_W'(DEPTH));
                end
                POP: begin
                    w_tos_nxt   = r_tos - PTR_W'(1);
                    w_count_nxt = r_count - CNT_W'(1);
                end
                REPLACE: begin
                    w_we_b      = 1'b1;
                end
                default: begin
                    w_we_b      = 1'b0;
                end
            endcase
        end else begin
            w_we_b = 1'b0;
        end
    end

    // Stack storage, pointer and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tos   <= PTR_W'(DEPTH - 1);
            r_count <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {AW{1'b0}};
            end
        end else begin
            r_tos   <= w_tos_nxt;
            r_count <= w_count_nxt;
            if (w_we_a) begin
                r_mem[w_wa_a] <= w_wd_a;
            end
            if (w_we_b) begin
                r_mem[w_wa_b] <= w_wd_b;
            end
        end
    end

    // A rollback clears the undone record and everything younger; survivors hold.
    assign w_id_load = ~PL_stall & ~w_rb_any;
    assign w_id_clr  = PL_flush | w_rb_any;
    assign w_ex_load = ~PL_stall & ~w_rb_any;
    assign w_ex_clr  = PL_flush | rollback_ex;

    ras_track_reg u_id_rec (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_id_load),
        .i_clr  (w_id_clr),
        .i_rec  (w_new_rec),
        .o_rec  (w_id_rec)
    );

    ras_track_reg u_ex_rec (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_ex_load),
        .i_clr  (w_ex_clr),
        .i_rec  (w_id_rec),
        .o_rec  (w_ex_rec)
    );

    assign top_addr  = r_mem[r_tos];
    assign top_valid = ~w_empty;
    assign ras_full  = (r_count == CNT_W'(DEPTH));

endmodule

// File: tb/tb_ras_ctrl.sv
// Self-checking bench for ras_ctrl: vector table, directed rollback sequences,
// and randomized traffic against a snapshot-based stack model.
module tb_ras_ctrl;

    localparam int D = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        push = 1'b0;
    logic [31:0] push_addr = 32'd0;
    logic        pop = 1'b0;
    logic        PL_stall = 1'b0;
    logic        PL_flush = 1'b0;
    logic        rollback_id = 1'b0;
    logic        rollback_ex = 1'b0;
    logic [31:0] top_addr;
    logic        top_valid;
    logic        ras_full;

    ras_ctrl #(.DEPTH(D), .AW(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .push_addr   (push_addr),
        .pop         (pop),
        .PL_stall    (PL_stall),
        .PL_flush    (PL_flush),
        .rollback_id (rollback_id),
        .rollback_ex (rollback_ex),
        .top_addr    (top_addr),
        .top_valid   (top_valid),
        .ras_full    (ras_full)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: each pending op remembers the whole stack as it was before it.
    typedef logic [31:0] mem_t [D];
    typedef struct {
        bit   valid;
        int   tos_b;
        int   cnt_b;
        int   slot;
        mem_t snap;
    } mrec_t;

    mem_t  m_mem;
    int    m_tos;
    int    m_count;
    mrec_t m_id;
    mrec_t m_ex;

    typedef struct {
        bit          pu;
        bit          po;
        logic [31:0] a;
        logic [31:0] e_top;
        bit          e_v;
        bit          e_f;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit pu, bit po, logic [31:0] a, logic [31:0] t, bit v, bit f);
        vec_t r;
        r.pu = pu; r.po = po; r.a = a; r.e_top = t; r.e_v = v; r.e_f = f;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input logic [31:0] t, input bit v, input bit f);
        chk({name, "_top"}, top_addr, t);
        chk({name, "_valid"}, {31'd0, top_valid}, {31'd0, v});
        chk({name, "_full"}, {31'd0, ras_full}, {31'd0, f});
    endtask

    task automatic model_step(input bit r, input bit pu, input bit po, input logic [31:0] a,
                              input bit st, input bit fl, input bit ri, input bit re);
        mrec_t nr;
        if (r) begin
            for (int i = 0; i < D; i++) m_mem[i] = 32'd0;
            m_tos = D - 1;
            m_count = 0;
            m_id.valid = 1'b0;
            m_ex.valid = 1'b0;
        end else if (ri || re) begin
            // undo the younger op first so the older snapshot has the last word
            if (ri && m_id.valid) begin
                m_mem[m_id.slot] = m_id.snap[m_id.slot];
                m_tos = m_id.tos_b;
                m_count = m_id.cnt_b;
            end
            if (re && m_ex.valid) begin
                m_mem[m_ex.slot] = m_ex.snap[m_ex.slot];
                m_tos = m_ex.tos_b;
                m_count = m_ex.cnt_b;
            end
            m_id.valid = 1'b0;
            if (re || fl) m_ex.valid = 1'b0;
        end else if (fl) begin
            m_id.valid = 1'b0;
            m_ex.valid = 1'b0;
        end else if (!st) begin
            nr.valid = 1'b0;
            nr.tos_b = m_tos;
            nr.cnt_b = m_count;
            nr.slot  = 0;
            nr.snap  = m_mem;
            if (pu) begin
                if (po && m_count != 0) begin
                    nr.slot = m_tos;
                end else begin
                    nr.slot = (m_tos + 1) % D;
                    m_tos = nr.slot;
                    m_count = (m_count + 1 > D) ? D : m_count + 1;
                end
                m_mem[nr.slot] = a;
                nr.valid = 1'b1;
            end else if (po && m_count > 0) begin
                nr.slot = m_tos;
                nr.valid = 1'b1;
                m_tos = (m_tos + D - 1) % D;
                m_count = m_count - 1;
            end
            m_ex = m_id;
            m_id = nr;
        end
    endtask

    task automatic drive(input bit r, input bit pu, input bit po, input logic [31:0] a,
                         input bit st, input bit fl, input bit ri, input bit re);
        rst = r; push = pu; pop = po; push_addr = a;
        PL_stall = st; PL_flush = fl; rollback_id = ri; rollback_ex = re;
        model_step(r, pu, po, a, st, fl, ri, re);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        bit pu, po, st, fl, ri, re, r;
        int push_w;

        do_reset();
        chk_out("reset", 32'd0, 1'b0, 1'b0);

        // Push/pop walk, including pop on empty, overflow wrap and drain.
        tbl.push_back(mk(1'b0, 1'b0, 32'h0,   32'h0,   1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 32'h100, 32'h100, 1'b1, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 32'h200, 32'h200, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 32'h0,   32'h100, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 32'h0,   32'h0,   1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 32'h0,   32'h0,   1'b0, 1'b0));
        for (int i = 1; i <= 9; i++)
            tbl.push_back(mk(1'b1, 1'b0, 32'(i * 16), 32'(i * 16), 1'b1, i >= 8));
        for (int k = 1; k <= 8; k++)
            tbl.push_back(mk(1'b0, 1'b1, 32'h0, (k < 8) ? 32'((9 - k) * 16) : 32'h90, k < 8, 1'b0));
        for (int i = 0; i < tbl.size(); i++) begin
            drive(1'b0, tbl[i].pu, tbl[i].po, tbl[i].a, 1'b0, 1'b0, 1'b0, 1'b0);
            chk_out($sformatf("vec%0d", i), tbl[i].e_top, tbl[i].e_v, tbl[i].e_f);
        end

        // rollback_id undoes a pop while the push sits in EX
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 32'h40, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0);
        chk_out("rbid_pre", 32'h0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b0);
        chk_out("rbid_post", 32'h40, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0);
        chk_out("rbid_cnt1", 32'h0, 1'b0, 1'b0);

        // both rollbacks undo two pushes
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 32'h40, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 32'h80, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b1);
        chk_out("rbboth_push", 32'h0, 1'b0, 1'b0);

        // both rollbacks on two replaces of the same slot: the older value wins
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 32'h11, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 32'h22, 1'b0, 1'b0, 1'b0, 1'b0);
        idle();
        idle();
        drive(1'b0, 1'b1, 1'b1, 32'h55, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 32'h66, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_out("repl_pre", 32'h66, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 32'h0,  1'b0, 1'b0, 1'b1, 1'b1);
        chk_out("repl_rbboth", 32'h22, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 32'h0,  1'b0, 1'b0, 1'b0, 1'b0);
        chk_out("repl_pop", 32'h11, 1'b1, 1'b0);

        // replace then rollback_ex two cycles later
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 32'h300, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 32'h500, 1'b0, 1'b0, 1'b0, 1'b0);
        chk_out("rbex_pre", 32'h500, 1'b1, 1'b0);
        idle();
        drive(1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b1);
        chk_out("rbex_post", 32'h300, 1'b1, 1'b0);

        // stall freezes stack and records
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 32'h300, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b0, 32'h777, 1'b1, 1'b0, 1'b0, 1'b0);
            chk_out($sformatf("stall%0d", i), 32'h300, 1'b1, 1'b0);
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk_out("stall_rbid", 32'h0, 1'b0, 1'b0);

        // flush blocks the op and clears records
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 32'h300, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 32'h777, 1'b0, 1'b1, 1'b0, 1'b0);
        chk_out("flush", 32'h300, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b1, 1'b0);
        chk_out("flush_rbid", 32'h300, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 1'b1);
        chk_out("flush_rbex", 32'h300, 1'b1, 1'b0);

        // reset beats a concurrent rollback and push
        drive(1'b1, 1'b1, 1'b0, 32'h999, 1'b0, 1'b0, 1'b1, 1'b1);
        chk_out("rst_mid", 32'h0, 1'b0, 1'b0);

        // randomized traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            push_w = ((c / 400) % 2 == 1) ? 65 : 35;
            r  = ($urandom_range(0, 299) == 0);
            pu = ($urandom_range(0, 99) < push_w);
            po = ($urandom_range(0, 99) < 40);
            st = ($urandom_range(0, 99) < 15);
            fl = ($urandom_range(0, 99) < 5);
            ri = ($urandom_range(0, 99) < 8);
            re = ($urandom_range(0, 99) < 8);
            drive(r, pu, po, $urandom, st, fl, ri, re);
            chk_out($sformatf("rnd%0d", c), m_mem[m_tos], m_count != 0, m_count == D);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
